// File: rtl/motor_drive_guard.sv
`default_nettype none
// ============================================================================
// Module      : motor_drive_guard
// Description : Guarded output stage between the manual/auto mode selector
//               and an L298-style H-bridge. All motor pins are active-low.
//               Each channel (A: IN1/IN2/ENA, B: IN3/IN4/ENB) runs its own
//               STOP/FWD/REV/DEAD state machine. The pins are held inactive
//               for DEAD_CYCLES clocks on every direction reversal and on every
//               mode change. Forward motion is blocked while an obstacle is
//               reported, and illegal 0/0 direction pairs are coerced to coast
//               and latch a sticky fault flag.
// Ports       : clock            - system clock (50 MHz domain)
//               reset            - asynchronous active-high reset
//               auto_mode_switch - mode select, any edge forces dead-time
//               object_detected  - asynchronous obstacle flag (1 = obstacle)
//               ENA_in/ENB_in    - active-low enables from the mode selector
//               IN1_in..IN4_in   - active-low direction pins from the selector
//               ENA/ENB, IN1..IN4 - guarded active-low pins to the H-bridge
//               state_a/state_b  - channel state 0=STOP 1=FWD 2=REV 3=DEAD
//               fault            - sticky illegal-command flag
// Revision    : 1.0 - initial release
// ============================================================================
module motor_drive_guard #(
  parameter int DEAD_CYCLES = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       auto_mode_switch,
  input  logic       object_detected,
  input  logic       ENA_in,
  input  logic       ENB_in,
  input  logic       IN1_in,
  input  logic       IN2_in,
  input  logic       IN3_in,
  input  logic       IN4_in,
  output logic       ENA,
  output logic       ENB,
  output logic       IN1,
  output logic       IN2,
  output logic       IN3,
  output logic       IN4,
  output logic [1:0] state_a,
  output logic [1:0] state_b,
  output logic       fault
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

  // Input conditioning registers
  logic obs_s1_q, obs_s1_d;
  logic obs_q, obs_d;
  logic mode_s1_q, mode_s1_d;
  logic mode_s2_q, mode_s2_d;
  logic mode_dly_q, mode_dly_d;
  logic init_q, init_d;
  logic mode_edge;

  // Channel state (index 0 = channel A, index 1 = channel B)
  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];

  // Registered pins, decoded from the next state
  logic [1:0] en_q, en_d;
  logic [1:0] ina_q, ina_d;
  logic [1:0] inb_q, inb_d;
  logic       fault_q, fault_d;

  // Raw request pins grouped per channel
  logic [1:0] req_en;
  logic [1:0] req_a;
  logic [1:0] req_b;
  logic [1:0] req_fwd;
  logic [1:0] req_rev;
  logic [1:0] req_illegal;

  assign req_en = {ENB_in, ENA_in};
  assign req_a  = {IN3_in, IN1_in};
  assign req_b  = {IN4_in, IN2_in};

  // --------------------------------------------------------------------------
  // Synchronizers. On the first clock after reset the whole mode chain is
  // loaded with the current switch level so that a switch already high at
  // reset release does not look like a mode change.
  // --------------------------------------------------------------------------
  always_comb begin
    obs_s1_d = object_detected;
    obs_d    = obs_s1_q;
    init_d   = 1'b1;
    if (!init_q) begin
      mode_s1_d  = auto_mode_switch;
      mode_s2_d  = auto_mode_switch;
      mode_dly_d = auto_mode_switch;
    end else begin
      mode_s1_d  = auto_mode_switch;
      mode_s2_d  = mode_s1_q;
      mode_dly_d = mode_s2_q;
    end
  end

  assign mode_edge = init_q & (mode_s2_q ^ mode_dly_q);

  // --------------------------------------------------------------------------
  // Request decode, channel next-state and pin decode
  // --------------------------------------------------------------------------
  always_comb begin
    req_fwd     = '0;
    req_rev     = '0;
    req_illegal = '0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    en_d        = '1;
    ina_d       = '1;
    inb_d       = '1;
    fault_d     = fault_q;

    for (int ch = 0; ch < 2; ch++) begin
      req_illegal[ch] = ~req_a[ch] & ~req_b[ch];
      // Reverse stays allowed with an obstacle so the rover can back away.
      req_fwd[ch]     = ~req_a[ch] & req_b[ch] & ~req_en[ch] & ~obs_q;
      req_rev[ch]     = req_a[ch] & ~req_b[ch] & ~req_en[ch];

      if (mode_edge) begin
        // Mode change wins over everything, including a DEAD in progress.
        state_d[ch] = ST_DEAD;
        cnt_d[ch]   = DEAD_LOAD;
      end else begin
        unique case (state_q[ch])
          ST_STOP: begin
            if (req_fwd[ch])      state_d[ch] = ST_FWD;
            else if (req_rev[ch]) state_d[ch] = ST_REV;
            else                  state_d[ch] = ST_STOP;
          end
          ST_FWD: begin
            if (req_rev[ch]) begin
              state_d[ch] = ST_DEAD;
              cnt_d[ch]   = DEAD_LOAD;
            end else if (req_fwd[ch]) begin
              state_d[ch] = ST_FWD;
            end else begin
              state_d[ch] = ST_STOP;
            end
          end
          ST_REV: begin
            if (req_fwd[ch]) begin
              state_d[ch] = ST_DEAD;
              cnt_d[ch]   = DEAD_LOAD;
            end else if (req_rev[ch]) begin
              state_d[ch] = ST_REV;
            end else begin
              state_d[ch] = ST_STOP;
            end
          end
          ST_DEAD: begin
            // Requests are ignored until the counter expires.
            if (cnt_q[ch] == '0) begin
              if (req_fwd[ch])      state_d[ch] = ST_FWD;
              else if (req_rev[ch]) state_d[ch] = ST_REV;
              else                  state_d[ch] = ST_STOP;
            end else begin
              cnt_d[ch] = cnt_q[ch] - 1'b1;
            end
          end
          default: state_d[ch] = ST_STOP;
        endcase
      end

      // Only FWD drives IN_a low and only REV drives IN_b low, so the pair
      // can never be 0/0.
      ina_d[ch] = (state_d[ch] != ST_FWD);
      inb_d[ch] = (state_d[ch] != ST_REV);
      en_d[ch]  = ~((state_d[ch] == ST_FWD) | (state_d[ch] == ST_REV));

      if (req_illegal[ch]) fault_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      obs_s1_q   <= 1'b0;
      obs_q      <= 1'b0;
      mode_s1_q  <= 1'b0;
      mode_s2_q  <= 1'b0;
      mode_dly_q <= 1'b0;
      init_q     <= 1'b0;
      state_q[0] <= ST_STOP;
      state_q[1] <= ST_STOP;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      en_q       <= '1;
      ina_q      <= '1;
      inb_q      <= '1;
      fault_q    <= 1'b0;
    end else begin
      obs_s1_q   <= obs_s1_d;
      obs_q      <= obs_d;
      mode_s1_q  <= mode_s1_d;
      mode_s2_q  <= mode_s2_d;
      mode_dly_q <= mode_dly_d;
      init_q     <= init_d;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      en_q       <= en_d;
      ina_q      <= ina_d;
      inb_q      <= inb_d;
      fault_q    <= fault_d;
    end
  end

  assign ENA     = en_q[0];
  assign ENB     = en_q[1];
  assign IN1     = ina_q[0];
  assign IN2     = inb_q[0];
  assign IN3     = ina_q[1];
  assign IN4     = inb_q[1];
  assign state_a = state_q[0];
  assign state_b = state_q[1];
  assign fault   = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_drive_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_drive_guard
// Description : Directed self-checking bench for motor_drive_guard with
//               DEAD_CYCLES = 4. Each check compares the packed observation
//               {state_a, ENA, IN1, IN2, state_b, ENB, IN3, IN4, fault}
//               against a hand-derived expected vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_drive_guard;

  localparam int DEAD_CYCLES = 4;
  localparam int CNT_W       = 16;

  localparam logic [1:0] S_STOP = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_REV  = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  localparam int CMD_STOP = 0;
  localparam int CMD_FWD  = 1;
  localparam int CMD_REV  = 2;
  localparam int CMD_ILL  = 3;

  logic clock = 1'b0;
  logic reset;
  logic auto_mode_switch;
  logic object_detected;
  logic ENA_in, ENB_in, IN1_in, IN2_in, IN3_in, IN4_in;
  logic ENA, ENB, IN1, IN2, IN3, IN4;
  logic [1:0] state_a, state_b;
  logic fault;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  motor_drive_guard #(
    .DEAD_CYCLES(DEAD_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .auto_mode_switch(auto_mode_switch),
    .object_detected (object_detected),
    .ENA_in          (ENA_in),
    .ENB_in          (ENB_in),
    .IN1_in          (IN1_in),
    .IN2_in          (IN2_in),
    .IN3_in          (IN3_in),
    .IN4_in          (IN4_in),
    .ENA             (ENA),
    .ENB             (ENB),
    .IN1             (IN1),
    .IN2             (IN2),
    .IN3             (IN3),
    .IN4             (IN4),
    .state_a         (state_a),
    .state_b         (state_b),
    .fault           (fault)
  );

  // {EN, IN_a, IN_b} expected for a channel state
  function automatic logic [2:0] pins(input logic [1:0] st);
    case (st)
      2'd1:    pins = 3'b001;
      2'd2:    pins = 3'b010;
      default: pins = 3'b111;
    endcase
  endfunction

  function automatic logic [10:0] exp_vec(input logic [1:0] sa, input logic [1:0] sb,
                                          input logic f);
    exp_vec = {sa, pins(sa), sb, pins(sb), f};
  endfunction

  task automatic chk(input string tag, input logic [10:0] expected);
    logic [10:0] observed;
    observed = {state_a, ENA, IN1, IN2, state_b, ENB, IN3, IN4, fault};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input int cmd);
    case (cmd)
      CMD_FWD: begin ENA_in = 1'b0; IN1_in = 1'b0; IN2_in = 1'b1; end
      CMD_REV: begin ENA_in = 1'b0; IN1_in = 1'b1; IN2_in = 1'b0; end
      CMD_ILL: begin ENA_in = 1'b0; IN1_in = 1'b0; IN2_in = 1'b0; end
      default: begin ENA_in = 1'b1; IN1_in = 1'b1; IN2_in = 1'b1; end
    endcase
  endtask

  task automatic set_b(input int cmd);
    case (cmd)
      CMD_FWD: begin ENB_in = 1'b0; IN3_in = 1'b0; IN4_in = 1'b1; end
      CMD_REV: begin ENB_in = 1'b0; IN3_in = 1'b1; IN4_in = 1'b0; end
      CMD_ILL: begin ENB_in = 1'b0; IN3_in = 1'b0; IN4_in = 1'b0; end
      default: begin ENB_in = 1'b1; IN3_in = 1'b1; IN4_in = 1'b1; end
    endcase
  endtask

  initial begin
    reset            = 1'b1;
    auto_mode_switch = 1'b0;
    object_detected  = 1'b0;
    set_a(CMD_STOP);
    set_b(CMD_STOP);

    // Reset state
    tick();
    tick();
    chk("reset_state", exp_vec(S_STOP, S_STOP, 1'b0));
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    chk("idle_after_reset", exp_vec(S_STOP, S_STOP, 1'b0));

    // 1. Channel A forward, one clock latency
    set_a(CMD_FWD);
    tick();
    chk("a_fwd", exp_vec(S_FWD, S_STOP, 1'b0));

    // 2. Reversal: 4 DEAD clocks, request toggling does not restart it
    set_a(CMD_REV);
    tick();
    chk("a_dead1", exp_vec(S_DEAD, S_STOP, 1'b0));
    set_a(CMD_FWD);
    tick();
    chk("a_dead2", exp_vec(S_DEAD, S_STOP, 1'b0));
    set_a(CMD_STOP);
    tick();
    chk("a_dead3", exp_vec(S_DEAD, S_STOP, 1'b0));
    set_a(CMD_REV);
    tick();
    chk("a_dead4", exp_vec(S_DEAD, S_STOP, 1'b0));
    tick();
    chk("a_rev_after_dead", exp_vec(S_REV, S_STOP, 1'b0));

    // 3. Mode toggle: 3-clock sync delay, both channels DEAD for 4 clocks
    set_a(CMD_STOP);
    set_b(CMD_REV);
    tick();
    chk("b_rev", exp_vec(S_STOP, S_REV, 1'b0));
    auto_mode_switch = 1'b1;
    tick();
    chk("mode_sync1", exp_vec(S_STOP, S_REV, 1'b0));
    tick();
    chk("mode_sync2", exp_vec(S_STOP, S_REV, 1'b0));
    tick();
    chk("mode_dead1", exp_vec(S_DEAD, S_DEAD, 1'b0));
    set_a(CMD_FWD);
    tick();
    chk("mode_dead2", exp_vec(S_DEAD, S_DEAD, 1'b0));
    tick();
    chk("mode_dead3", exp_vec(S_DEAD, S_DEAD, 1'b0));
    tick();
    chk("mode_dead4", exp_vec(S_DEAD, S_DEAD, 1'b0));
    tick();
    chk("mode_resume", exp_vec(S_FWD, S_REV, 1'b0));

    // 4. Obstacle while forward: stop 3 clocks later, reverse still allowed
    object_detected = 1'b1;
    tick();
    chk("obs_lat1", exp_vec(S_FWD, S_REV, 1'b0));
    tick();
    chk("obs_lat2", exp_vec(S_FWD, S_REV, 1'b0));
    tick();
    chk("obs_stop", exp_vec(S_STOP, S_REV, 1'b0));
    tick();
    chk("obs_fwd_blocked", exp_vec(S_STOP, S_REV, 1'b0));
    set_a(CMD_REV);
    tick();
    chk("obs_rev_no_dead", exp_vec(S_REV, S_REV, 1'b0));
    // Obstacle clears: forward is still masked for the 2 sync clocks
    object_detected = 1'b0;
    set_a(CMD_FWD);
    tick();
    chk("obs_clear1", exp_vec(S_STOP, S_REV, 1'b0));
    tick();
    chk("obs_clear2", exp_vec(S_STOP, S_REV, 1'b0));
    tick();
    chk("obs_fwd_restored", exp_vec(S_FWD, S_REV, 1'b0));

    // 5. Illegal pair on channel B: coast, sticky fault
    set_b(CMD_ILL);
    tick();
    chk("b_illegal", exp_vec(S_FWD, S_STOP, 1'b1));
    set_b(CMD_REV);
    tick();
    chk("fault_sticky", exp_vec(S_FWD, S_REV, 1'b1));

    // 6. Asynchronous reset in the middle of DEAD
    set_a(CMD_REV);
    tick();
    chk("pre_reset_dead", exp_vec(S_DEAD, S_REV, 1'b1));
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", exp_vec(S_STOP, S_STOP, 1'b0));
    set_a(CMD_STOP);
    set_b(CMD_STOP);
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    chk("post_reset_idle", exp_vec(S_STOP, S_STOP, 1'b0));
    set_a(CMD_FWD);
    tick();
    chk("post_reset_fwd", exp_vec(S_FWD, S_STOP, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
